cfu_requant: RTL and testbench
==============================

// Module: cfu_requant
// PURPOSE
//  Output stage downstream of the MAC CFU. Takes a raw int32 convolution accumulator and requantises it to int8:
//  bias add, fixed-point multiplier, rounding shift, output offset and activation clamp, TFLite-exact.
//  Same cmd/rsp CFU handshake as the MAC CFU. Multi-cycle and non-pipelined: one op in flight.
// PARAMETERS
//  LAT_FIXED   3   cycles from requant accept to rsp_valid; the only legal value is 3, checked by the bench
// PORTS
//  clk                      in   1   single clock, rising edge
//  reset                    in   1   asynchronous assert, active-low (0 = reset)
//  cmd_valid                in   1   command offered
//  cmd_ready                out  1   high only in IDLE
//  cmd_payload_function_id  in   10  [2:0] op select; [9:3] ignored
//  cmd_payload_inputs_0     in   32  operand A
//  cmd_payload_inputs_1     in   32  operand B
//  rsp_valid                out  1   result held until rsp_ready
//  rsp_ready                in   1   CPU accepts the result
//  rsp_payload_outputs_0    out  32  result
// BEHAVIOUR
//  Reset (reset=0): rsp_valid=0, rsp_payload_outputs_0=0, state=IDLE.
//   Config regs reset to: bias=0, mult=0, shift=0, out_off=0, act_min=-128, act_max=127, pack=0.
//  Accept = cmd_valid & cmd_ready at a clk edge. Ops by function_id[2:0]:
//   0 SET_BIAS   bias<=in0
//   1 SET_MULT   mult<=in0; shift<=in1[5:0] (signed, -31..+31; values outside are clamped to that range)
//   2 SET_OUT    out_off<=in0; act_min<=in1[7:0]; act_max<=in1[15:8] (int8)
//   3 REQUANT    result = sign-extended int8 of requant(in0)
//   4 PACK_PUSH  requant(in0); pack<={q,pack[31:8]}; result = the new pack value
//   5 PACK_CLR   pack<=0
//   6,7          no-op
//  Ops 0,1,2,5,6,7: 1-cycle latency (IDLE->RESP); rsp_payload_outputs_0 = 0.
//  Ops 3,4: FSM IDLE->BIAS->MUL->SHIFT->RESP; rsp_valid rises exactly 3 edges after the accept edge.
//  RESP: rsp_valid=1 with payload stable; goes to IDLE on the edge where rsp_ready=1.
//   cmd_ready=0 in every state except IDLE.
//  Arithmetic (all values two's complement):
//   x = in0 + bias, 32-bit wrap.
//   x = x << max(shift,0), 32-bit wrap.
//   SRDHM(x,mult):
//    if x == mult == 0x80000000, result is 0x7FFFFFFF.
//    otherwise p = 64-bit x*mult; add nudge (2^30 if p>=0, else 1-2^30); divide by 2^31, truncating toward zero.
//   RDBP by e = max(-shift,0):
//    mask = 2^e - 1; rem = v & mask; thr = (mask>>1) + (v<0).
//    result = (v >>> e) + (rem > thr).
//   y = result + out_off, 32-bit. Clamp y to [act_min, act_max]; q = y[7:0].
//   act_min > act_max is not checked; the clamp applies max first, then min.
//  Config registers update on the accept edge. An op already in flight uses the values latched at its own accept.
//  Reset mid-operation: the op is discarded, no response is produced, config regs return to reset values.
// CONFIGURATION
//  REQUANT_PACK_EN defined: ops 4 and 5 as above, with a 32-bit pack register.
//  REQUANT_PACK_EN undefined: ops 4 and 5 are 1-cycle no-ops returning 0, and no pack register exists.
// STRUCTURE
//  Package cfu_requant_pkg: op-code localparams (OP_SET_BIAS..OP_PACK_CLR), state enum,
//   INT8_MIN/INT8_MAX, NUDGE_POS/NUDGE_NEG.
//  One sub-module: requant_srdhm, the registered 32x32->64 multiply with nudge and saturation (the MUL stage).
// TESTING
//  Setup used by all cases unless stated: mult=0x40000000, shift=0, bias=0, out_off=0, min/max=-128/127.
//  T1 REQUANT 100 -> 0x00000032 (50); rsp_valid 3 edges after accept; cmd_ready=0 meanwhile.
//  T2 REQUANT 1000 -> 0x0000007F (clamp high).
//     out_off=-128, REQUANT -100 -> 0xFFFFFF80 (clamp low).
//  T3 shift=-1, REQUANT 101 -> 0x0000001A (26); SRDHM gives 51, RDBP rounds up.
//  T4 mult=0x80000000, REQUANT 0x80000000 -> saturates to 0x7FFFFFFF -> 0x0000007F.
//  T5 (REQUANT_PACK_EN) PACK_CLR, then PACK_PUSH of 2,4,6,8 -> final payload 0x04030201.
//  T6 Hold rsp_ready=0 for 5 cycles: payload stays stable, cmd_ready stays 0.
//     Assert reset in the MUL state: rsp_valid stays 0, next REQUANT uses reset config and returns 0.

Source files
------------

// File: rtl/cfu_requant_pkg.sv
// Shared op codes, FSM state encoding and fixed-point constants for cfu_requant.
package cfu_requant_pkg;

   localparam logic [2:0] OP_SET_BIAS  = 3'd0;
   localparam logic [2:0] OP_SET_MULT  = 3'd1;
   localparam logic [2:0] OP_SET_OUT   = 3'd2;
   localparam logic [2:0] OP_REQUANT   = 3'd3;
   localparam logic [2:0] OP_PACK_PUSH = 3'd4;
   localparam logic [2:0] OP_PACK_CLR  = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_BIAS  = 3'd1,
      ST_MUL   = 3'd2,
      ST_SHIFT = 3'd3,
      ST_RESP  = 3'd4
   } state_t;

   localparam logic [7:0] INT8_MIN = 8'h80;
   localparam logic [7:0] INT8_MAX = 8'h7F;

   // Rounding nudges applied to the 64-bit product before the divide by 2^31.
   localparam logic signed [63:0] NUDGE_POS = 64'sh0000_0000_4000_0000;
   localparam logic signed [63:0] NUDGE_NEG = 64'shFFFF_FFFF_C000_0001;

endpackage

// File: rtl/cfu_requant_srdhm.sv
// Registered saturating rounding doubling high multiply (the MUL stage of cfu_requant).
module requant_srdhm
   import cfu_requant_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [31:0] x,
   input  logic [31:0] mult,
   output logic [31:0] y
);

   logic signed [63:0] x_ext;
   logic signed [63:0] m_ext;
   logic signed [63:0] prod;
   logic signed [63:0] nudged;
   logic signed [63:0] adj;
   logic signed [63:0] quo;
   logic               sat;
   logic               unused_hi;

   assign x_ext  = {{32{x[31]}}, x};
   assign m_ext  = {{32{mult[31]}}, mult};
   assign prod   = x_ext * m_ext;
   assign nudged = prod + (prod[63] ? NUDGE_NEG : NUDGE_POS);
   // Bias negative values up so the arithmetic shift truncates toward zero.
   assign adj    = nudged[63] ? (nudged + 64'sh0000_0000_7FFF_FFFF) : nudged;
   assign quo    = adj >>> 31;
   assign sat    = (x == 32'h8000_0000) && (mult == 32'h8000_0000);

   assign unused_hi = ^quo[63:32];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         y <= 32'd0;
      end else if (en) begin
         y <= sat ? 32'h7FFF_FFFF : quo[31:0];
      end
   end

endmodule

// File: rtl/cfu_requant.sv
// int32 accumulator -> int8 requantiser behind a CFU cmd/rsp handshake, one op in flight.
// Optional REQUANT_PACK_EN adds a 4-byte pack register (ops PACK_PUSH / PACK_CLR).
//
// state    | meaning
// ST_IDLE  | waiting for a command, cmd_ready=1
// ST_BIAS  | add bias, apply left shift
// ST_MUL   | SRDHM multiply registered
// ST_SHIFT | rounding right shift, offset, clamp, load result
// ST_RESP  | rsp_valid=1 until rsp_ready
module cfu_requant
   import cfu_requant_pkg::*;
#(
   parameter int LAT_FIXED = 3
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [9:0]  cmd_payload_function_id,
   input  logic [31:0] cmd_payload_inputs_0,
   input  logic [31:0] cmd_payload_inputs_1,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_payload_outputs_0
);

   if (LAT_FIXED != 3) begin : g_bad_lat
      $error("cfu_requant: LAT_FIXED must be 3");
   end

   state_t             state;
   logic [31:0]        bias_r;
   logic [31:0]        mult_r;
   logic [31:0]        out_off_r;
   logic [31:0]        x_r;
   logic signed [5:0]  shift_r;
   logic [7:0]         act_min_r;
   logic [7:0]         act_max_r;
`ifdef REQUANT_PACK_EN
   logic [31:0]        pack_r;
   logic               push_r;
`endif

   logic [2:0]         op;
   logic signed [5:0]  shift_in;
   logic signed [5:0]  shift_sat;
   logic [5:0]         neg_shift;
   logic [4:0]         lshift;
   logic [4:0]         rshift;
   logic [31:0]        x_scaled;
   logic [31:0]        srdhm_y;
   logic [31:0]        mask;
   logic [31:0]        rem;
   logic [31:0]        thr;
   logic [31:0]        v_sra;
   logic [31:0]        rdbp;
   logic signed [31:0] y_s;
   logic signed [31:0] min_s;
   logic signed [31:0] max_s;
   logic signed [31:0] y_lo;
   logic signed [31:0] y_cl;
   logic [7:0]         q;
   logic               unused_bits;

   assign op        = cmd_payload_function_id[2:0];
   assign cmd_ready = (state == ST_IDLE);
   assign rsp_valid = (state == ST_RESP);

   // A 6-bit field can carry -32, which is outside the legal shift range.
   assign shift_in  = cmd_payload_inputs_1[5:0];
   assign shift_sat = (shift_in == -6'sd32) ? -6'sd31 : shift_in;

   assign neg_shift = -shift_r;
   assign lshift    = shift_r[5] ? 5'd0 : shift_r[4:0];
   assign rshift    = shift_r[5] ? neg_shift[4:0] : 5'd0;
   assign x_scaled  = (x_r + bias_r) << lshift;

   requant_srdhm u_srdhm (
      .clk   (clk),
      .reset (reset),
      .en    (state == ST_MUL),
      .x     (x_r),
      .mult  (mult_r),
      .y     (srdhm_y)
   );

   assign mask  = (32'd1 << rshift) - 32'd1;
   assign rem   = srdhm_y & mask;
   assign thr   = (mask >> 1) + {31'd0, srdhm_y[31]};
   assign v_sra = $signed(srdhm_y) >>> rshift;
   assign rdbp  = v_sra + {31'd0, (rem > thr)};

   assign y_s   = rdbp + out_off_r;
   assign min_s = {{24{act_min_r[7]}}, act_min_r};
   assign max_s = {{24{act_max_r[7]}}, act_max_r};
   assign y_lo  = (y_s < min_s) ? min_s : y_s;
   assign y_cl  = (y_lo > max_s) ? max_s : y_lo;
   assign q     = y_cl[7:0];

   assign unused_bits = ^{cmd_payload_function_id[9:3], cmd_payload_inputs_1[31:16],
                          neg_shift[5], y_cl[31:8]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state                 <= ST_IDLE;
         bias_r                <= 32'd0;
         mult_r                <= 32'd0;
         shift_r               <= 6'sd0;
         out_off_r             <= 32'd0;
         act_min_r             <= INT8_MIN;
         act_max_r             <= INT8_MAX;
         x_r                   <= 32'd0;
         rsp_payload_outputs_0 <= 32'd0;
`ifdef REQUANT_PACK_EN
         pack_r                <= 32'd0;
         push_r                <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  x_r                   <= cmd_payload_inputs_0;
                  rsp_payload_outputs_0 <= 32'd0;
                  state                 <= ST_RESP;
                  case (op)
                     OP_SET_BIAS: bias_r <= cmd_payload_inputs_0;
                     OP_SET_MULT: begin
                        mult_r  <= cmd_payload_inputs_0;
                        shift_r <= shift_sat;
                     end
                     OP_SET_OUT: begin
                        out_off_r <= cmd_payload_inputs_0;
                        act_min_r <= cmd_payload_inputs_1[7:0];
                        act_max_r <= cmd_payload_inputs_1[15:8];
                     end
                     OP_REQUANT: begin
                        state <= ST_BIAS;
`ifdef REQUANT_PACK_EN
                        push_r <= 1'b0;
`endif
                     end
`ifdef REQUANT_PACK_EN
                     OP_PACK_PUSH: begin
                        state  <= ST_BIAS;
                        push_r <= 1'b1;
                     end
                     OP_PACK_CLR: pack_r <= 32'd0;
`endif
                     default: ;
                  endcase
               end
            end
            ST_BIAS: begin
               x_r   <= x_scaled;
               state <= ST_MUL;
            end
            ST_MUL: state <= ST_SHIFT;
            ST_SHIFT: begin
`ifdef REQUANT_PACK_EN
               if (push_r) begin
                  pack_r                <= {q, pack_r[31:8]};
                  rsp_payload_outputs_0 <= {q, pack_r[31:8]};
               end else begin
                  rsp_payload_outputs_0 <= {{24{q[7]}}, q};
               end
`else
               rsp_payload_outputs_0 <= {{24{q[7]}}, q};
`endif
               state <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cfu_requant.sv
// Self-checking bench for cfu_requant: directed cases plus randomized ops against a reference model.
module tb_cfu_requant;

   localparam int LAT_FIXED = 3;

   logic        clk;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [9:0]  cmd_payload_function_id;
   logic [31:0] cmd_payload_inputs_0;
   logic [31:0] cmd_payload_inputs_1;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_payload_outputs_0;

   int nvec;
   int nfail;

   // reference model state
   int          m_bias, m_mult, m_shift, m_off, m_min, m_max;
   logic [31:0] m_pack;

   cfu_requant #(.LAT_FIXED(LAT_FIXED)) dut (
      .clk                     (clk),
      .reset                   (reset),
      .cmd_valid               (cmd_valid),
      .cmd_ready               (cmd_ready),
      .cmd_payload_function_id (cmd_payload_function_id),
      .cmd_payload_inputs_0    (cmd_payload_inputs_0),
      .cmd_payload_inputs_1    (cmd_payload_inputs_1),
      .rsp_valid               (rsp_valid),
      .rsp_ready               (rsp_ready),
      .rsp_payload_outputs_0   (rsp_payload_outputs_0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic void model_reset();
      m_bias = 0; m_mult = 0; m_shift = 0; m_off = 0;
      m_min = -128; m_max = 127; m_pack = 32'd0;
   endfunction

   // TFLite MultiplyByQuantizedMultiplier followed by offset and clamp, in plain integer arithmetic.
   function automatic logic [7:0] ref_q(input int a);
      int     x, r, v, y, e;
      longint p, mask, rem, thr;
      logic [31:0] yb;
      x = a + m_bias;
      if (m_shift > 0) x = x << m_shift;
      if (x == int'(32'h8000_0000) && m_mult == int'(32'h8000_0000)) begin
         r = int'(32'h7FFF_FFFF);
      end else begin
         p = longint'(x) * longint'(m_mult);
         p = p + ((p >= 0) ? 64'sd1073741824 : (64'sd1 - 64'sd1073741824));
         r = int'(p / 64'sd2147483648);
      end
      e    = (m_shift < 0) ? -m_shift : 0;
      mask = (64'sd1 <<< e) - 64'sd1;
      rem  = longint'(r) & mask;
      thr  = (mask >>> 1) + ((r < 0) ? 64'sd1 : 64'sd0);
      v    = (r >>> e) + ((rem > thr) ? 1 : 0);
      y    = v + m_off;
      if (y < m_min) y = m_min;
      if (y > m_max) y = m_max;
      yb = y;
      return yb[7:0];
   endfunction

   function automatic void model_op(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] res, output int lat);
      logic [7:0]        q;
      logic signed [5:0] s;
      logic signed [7:0] lo, hi;
      res = 32'd0;
      lat = 0;
      case (fid[2:0])
         3'd0: m_bias = a;
         3'd1: begin
            m_mult = a;
            s = b[5:0];
            m_shift = (s == -6'sd32) ? -31 : int'(s);
         end
         3'd2: begin
            m_off = a;
            lo = b[7:0];
            hi = b[15:8];
            m_min = int'(lo);
            m_max = int'(hi);
         end
         3'd3: begin
            q = ref_q(a);
            res = {{24{q[7]}}, q};
            lat = LAT_FIXED;
         end
`ifdef REQUANT_PACK_EN
         3'd4: begin
            q = ref_q(a);
            m_pack = {q, m_pack[31:8]};
            res = m_pack;
            lat = LAT_FIXED;
         end
         3'd5: m_pack = 32'd0;
`endif
         default: ;
      endcase
   endfunction

   // Drive one command, wait (bounded) for the response, sample it and hand it back.
   task automatic do_op(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output logic busy_ok);
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_payload_function_id = fid;
      cmd_payload_inputs_0 = a;
      cmd_payload_inputs_1 = b;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      lat = 0;
      busy_ok = 1'b1;
      while (rsp_valid !== 1'b1 && lat < 20) begin
         if (cmd_ready !== 1'b0) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      res = rsp_payload_outputs_0;
      if (cmd_ready !== 1'b0) busy_ok = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      nvec++;
      if (rsp_valid !== 1'b0) begin
         nfail++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid);
      end
      nvec++;
      if (rsp_payload_outputs_0 !== 32'd0) begin
         nfail++; $display("FAIL reset_payload got %h want 00000000", rsp_payload_outputs_0);
      end
      reset = 1'b1;
      @(negedge clk);
      nvec++;
      if (cmd_ready !== 1'b1) begin
         nfail++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready);
      end
   endtask

   task automatic setup_default();
      logic [31:0] r, e;
      int l, el;
      logic b;
      model_op(10'd1, 32'h4000_0000, 32'd0, e, el);  do_op(10'd1, 32'h4000_0000, 32'd0, r, l, b);
      model_op(10'd0, 32'd0, 32'd0, e, el);          do_op(10'd0, 32'd0, 32'd0, r, l, b);
      model_op(10'd2, 32'd0, 32'h7F80, e, el);       do_op(10'd2, 32'd0, 32'h7F80, r, l, b);
   endtask

   task automatic test_directed();
      logic [31:0] r, e;
      int l, el;
      logic b;
      setup_default();
      // T1
      model_op(10'd3, 32'd100, 32'd0, e, el);
      do_op(10'd3, 32'd100, 32'd0, r, l, b);
      nvec++;
      if (r !== 32'h32 || e !== 32'h32) begin
         nfail++; $display("FAIL t1_value got %h want 00000032 (model %h)", r, e);
      end
      nvec++;
      if (l != 3) begin
         nfail++; $display("FAIL t1_latency got %0d want 3", l);
      end
      nvec++;
      if (b !== 1'b1) begin
         nfail++; $display("FAIL t1_cmd_ready_busy got high while in flight, want low");
      end
      // T2
      do_op(10'd3, 32'd1000, 32'd0, r, l, b);
      nvec++;
      if (r !== 32'h7F) begin
         nfail++; $display("FAIL t2_clamp_high got %h want 0000007f", r);
      end
      model_op(10'd2, 32'hFFFF_FF80, 32'h7F80, e, el);
      do_op(10'd2, 32'hFFFF_FF80, 32'h7F80, r, l, b);
      nvec++;
      if (r !== 32'd0 || l != 0) begin
         nfail++; $display("FAIL set_out_resp got %h lat %0d want 00000000 lat 0", r, l);
      end
      do_op(10'd3, 32'hFFFF_FF9C, 32'd0, r, l, b);
      nvec++;
      if (r !== 32'hFFFF_FF80) begin
         nfail++; $display("FAIL t2_clamp_low got %h want ffffff80", r);
      end
      // T3
      setup_default();
      model_op(10'd1, 32'h4000_0000, 32'h3F, e, el);
      do_op(10'd1, 32'h4000_0000, 32'h3F, r, l, b);
      do_op(10'd3, 32'd101, 32'd0, r, l, b);
      nvec++;
      if (r !== 32'h1A) begin
         nfail++; $display("FAIL t3_rdbp_round got %h want 0000001a", r);
      end
      // T4
      setup_default();
      model_op(10'd1, 32'h8000_0000, 32'd0, e, el);
      do_op(10'd1, 32'h8000_0000, 32'd0, r, l, b);
      do_op(10'd3, 32'h8000_0000, 32'd0, r, l, b);
      nvec++;
      if (r !== 32'h7F) begin
         nfail++; $display("FAIL t4_saturate got %h want 0000007f", r);
      end
      // shift field -32 is clamped to -31: 0x7FFFFFFF after SRDHM by 0x7FFFFFFF, >>31 rounds to 1
      model_op(10'd1, 32'h7FFF_FFFF, 32'h20, e, el);
      do_op(10'd1, 32'h7FFF_FFFF, 32'h20, r, l, b);
      model_op(10'd3, 32'h7FFF_FFFF, 32'd0, e, el);
      do_op(10'd3, 32'h7FFF_FFFF, 32'd0, r, l, b);
      nvec++;
      if (r !== 32'h1 || e !== 32'h1) begin
         nfail++; $display("FAIL shift_clamp got %h want 00000001 (model %h)", r, e);
      end
   endtask

   task automatic test_noop_ops();
      logic [31:0] r;
      int l;
      logic b;
      for (int i = 5; i < 8; i++) begin
`ifdef REQUANT_PACK_EN
         if (i == 5) continue;
`endif
         do_op({7'h55, 3'(i)}, $urandom, $urandom, r, l, b);
         nvec++;
         if (r !== 32'd0 || l != 0) begin
            nfail++; $display("FAIL noop_op%0d got %h lat %0d want 00000000 lat 0", i, r, l);
         end
      end
`ifndef REQUANT_PACK_EN
      do_op(10'd4, 32'd2, 32'd0, r, l, b);
      nvec++;
      if (r !== 32'd0 || l != 0) begin
         nfail++; $display("FAIL push_disabled got %h lat %0d want 00000000 lat 0", r, l);
      end
`endif
   endtask

   task automatic test_pack();
      logic [31:0] r, e;
      int l, el;
      logic b;
      setup_default();
      model_op(10'd5, 32'd0, 32'd0, e, el);
      do_op(10'd5, 32'd0, 32'd0, r, l, b);
      for (int i = 1; i <= 4; i++) begin
         model_op(10'd4, 32'(2 * i), 32'd0, e, el);
         do_op(10'd4, 32'(2 * i), 32'd0, r, l, b);
         nvec++;
         if (r !== e || l != el) begin
            nfail++; $display("FAIL pack_push%0d got %h lat %0d want %h lat %0d", i, r, l, e, el);
         end
      end
`ifdef REQUANT_PACK_EN
      nvec++;
      if (r !== 32'h0403_0201) begin
         nfail++; $display("FAIL t5_pack_final got %h want 04030201", r);
      end
`endif
   endtask

   task automatic test_hold();
      logic [31:0] p0;
      int          n;
      setup_default();
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_payload_function_id = 10'd3;
      cmd_payload_inputs_0 = 32'd100;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      p0 = rsp_payload_outputs_0;
      nvec++;
      if (p0 !== 32'h32) begin
         nfail++; $display("FAIL hold_value got %h want 00000032", p0);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         nvec++;
         if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_payload_outputs_0 !== p0) begin
            nfail++;
            $display("FAIL hold_cycle%0d got valid %b ready %b data %h want 1 0 %h",
                     i, rsp_valid, cmd_ready, rsp_payload_outputs_0, p0);
         end
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [31:0] r, e;
      int l, el;
      logic b;
      setup_default();
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_payload_function_id = 10'd3;
      cmd_payload_inputs_0 = 32'd100;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         nvec++;
         if (rsp_valid !== 1'b0) begin
            nfail++; $display("FAIL midreset_valid%0d got %b want 0", i, rsp_valid);
         end
      end
      reset = 1'b1;
      @(negedge clk);
      nvec++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         nfail++; $display("FAIL midreset_after got valid %b ready %b want 0 1", rsp_valid, cmd_ready);
      end
      model_op(10'd3, 32'd100, 32'd0, e, el);
      do_op(10'd3, 32'd100, 32'd0, r, l, b);
      nvec++;
      if (r !== 32'd0 || e !== 32'd0) begin
         nfail++; $display("FAIL midreset_config got %h want 00000000 (model %h)", r, e);
      end
   endtask

   task automatic test_random();
      logic [31:0] r, e, a, bb;
      logic [9:0]  fid;
      int          l, el, sel;
      logic        b;
      for (int i = 0; i < 300; i++) begin
         sel = $urandom_range(0, 15);
         if (sel < 7)       fid = 10'd3;
         else if (sel < 9)  fid = 10'd4;
         else if (sel == 9) fid = 10'd0;
         else if (sel == 10) fid = 10'd1;
         else if (sel == 11) fid = 10'd2;
         else               fid = 10'($urandom_range(5, 7));
         fid[9:3] = 7'($urandom);
         a  = $urandom;
         bb = $urandom;
         if (fid[2:0] == 3'd0 && sel[0]) a = 32'($urandom_range(0, 2000)) - 32'd1000;
         if (fid[2:0] == 3'd2 && sel[0]) a = 32'($urandom_range(0, 255)) - 32'd128;
         if ((fid[2:0] == 3'd3 || fid[2:0] == 3'd4) && sel[1]) a = 32'($urandom_range(0, 200000)) - 32'd100000;
         model_op(fid, a, bb, e, el);
         do_op(fid, a, bb, r, l, b);
         nvec++;
         if (r !== e || l != el || b !== 1'b1) begin
            nfail++;
            $display("FAIL random%0d op %0d in0 %h in1 %h got %h lat %0d want %h lat %0d",
                     i, fid[2:0], a, bb, r, l, e, el);
         end
      end
   endtask

   initial begin
      nvec = 0;
      nfail = 0;
      reset = 1'b0;
      cmd_valid = 1'b0;
      cmd_payload_function_id = 10'd0;
      cmd_payload_inputs_0 = 32'd0;
      cmd_payload_inputs_1 = 32'd0;
      rsp_ready = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      test_reset();
      test_directed();
      test_noop_ops();
      test_pack();
      test_hold();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
